fifo_word_packer: RTL and testbench



---
 rtl/fifo_word_packer.sv | 133 +++++++++++++
 tb/tb_fifo_word_packer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Read-side FIFO consumer: pops bytes, packs LANES of them into one word.
// Optional partial-word flush on idle timeout when PACKER_TIMEOUT_EN is defined.
//
// Ports:
//   CLK, RST      read-domain clock, synchronous active-high reset
//   EMPTY, R_DATA show-ahead FIFO head and its empty flag
//   R_INC         pop strobe (combinational)
//   OUT_DATA      packed word, lane 0 = oldest byte
//   OUT_BYTE_EN   per-lane valid mask
//   OUT_VALID, OUT_READY  output handshake
module fifo_word_packer #(
  parameter int D_SIZE  = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EMPTY,
  input  logic [D_SIZE-1:0]         R_DATA,
  output logic                      R_INC,
  output logic [D_SIZE*LANES-1:0]   OUT_DATA,
  output logic [LANES-1:0]          OUT_BYTE_EN,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]           cnt;
  logic [D_SIZE*LANES-1:0] lane_q;
  logic [LANES-1:0]        be_q;
  logic                    pop;
  logic                    flush;
  logic [LANES-1:0]        flush_mask;

  assign pop   = ~RST & ~EMPTY & (state == COLLECT);
  assign R_INC = pop;

`ifdef PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle;

  // A pop on the same edge always wins over the flush.
  assign flush = (state == COLLECT) & (cnt != '0)
               & EMPTY & (idle == IDLE_LAST);

  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < cnt) flush_mask[i] = 1'b1;
    end
  end

  // Saturating so it can never wrap back under the threshold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle <= '0;
    end else if (state != COLLECT || pop || flush) begin
      idle <= '0;
    end else if (cnt != '0 && EMPTY && idle != '1) begin
      idle <= idle + 1'b1;
    end
  end
`else
  assign flush      = 1'b0;
  assign flush_mask = '1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: begin
        if ((pop && cnt == LAST) || flush) state_nxt = SEND;
      end
      SEND: begin
        if (OUT_READY) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      lane_q <= '0;
      be_q   <= '0;
    end else if (state == COLLECT) begin
      unique case (1'b1)
        pop: begin
          for (int i = 0; i < LANES; i++) begin
            if (cnt == CW'(i)) lane_q[i*D_SIZE +: D_SIZE] <= R_DATA;
          end
          if (cnt == LAST) begin
            cnt  <= '0;
            be_q <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        flush: begin
          cnt  <= '0;
          be_q <= flush_mask;
        end
        default: ;
      endcase
    end else if (OUT_READY) begin
      // Unwritten lanes of the next word must read as zero.
      lane_q <= '0;
      be_q   <= '0;
    end
  end

  assign OUT_DATA    = lane_q;
  assign OUT_BYTE_EN = be_q;
  assign OUT_VALID   = (state == SEND);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: FIFO model feeding the packer,
// scoreboard of expected words checked at each output handshake.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int TO = 16;
  localparam int WW = DW * L;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EMPTY;
  logic [DW-1:0] R_DATA;
  logic          R_INC;
  logic [WW-1:0] OUT_DATA;
  logic [L-1:0]  OUT_BYTE_EN;
  logic          OUT_VALID;
  logic          OUT_READY;

  always #5 CLK = ~CLK;

  fifo_word_packer #(
    .D_SIZE (DW),
    .LANES  (L),
    .TIMEOUT(TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EMPTY      (EMPTY),
    .R_DATA     (R_DATA),
    .R_INC      (R_INC),
    .OUT_DATA   (OUT_DATA),
    .OUT_BYTE_EN(OUT_BYTE_EN),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY)
  );

  typedef struct packed {
    logic [WW-1:0] data;
    logic [L-1:0]  be;
  } word_t;

  logic [DW-1:0] fq[$];
  word_t         exp_q[$];

  int checks       = 0;
  int failures     = 0;
  int edges        = 0;
  int pop_edge     = 0;
  int rise_edge    = 0;
  int valid_cycles = 0;

  bit            gate_empty = 1'b0;
  bit            prev_valid = 1'b0;
  logic [WW-1:0] prev_data  = '0;
  logic [L-1:0]  prev_be    = '0;

  task automatic push_exp(input logic [WW-1:0] d,
                          input logic [L-1:0] be);
    word_t w;
    w.data = d;
    w.be   = be;
    exp_q.push_back(w);
  endtask

  task automatic push_word(input logic [DW-1:0] b0,
                           input logic [DW-1:0] b1,
                           input logic [DW-1:0] b2,
                           input logic [DW-1:0] b3);
    fq.push_back(b0);
    fq.push_back(b1);
    fq.push_back(b2);
    fq.push_back(b3);
    push_exp({b3, b2, b1, b0}, 4'hF);
  endtask

  // One clock: drive FIFO model at negedge, sample, then take the edge.
  task automatic step();
    logic  pop_now;
    logic  hs;
    logic  exp_rinc;
    word_t w;
    EMPTY  = gate_empty || (fq.size() == 0);
    R_DATA = (fq.size() != 0) ? fq[0] : '0;
    #1;
    pop_now  = R_INC;
    hs       = OUT_VALID & OUT_READY;
    exp_rinc = !RST && !EMPTY && (OUT_VALID !== 1'b1);
    checks++;
    if (R_INC !== exp_rinc) begin
      failures++;
      $display("FAIL r_inc edge=%0d got=%b want=%b",
               edges, R_INC, exp_rinc);
    end
    if (prev_valid && !RST) begin
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== prev_data ||
          OUT_BYTE_EN !== prev_be) begin
        failures++;
        $display("FAIL hold edge=%0d got=%b/%h/%h want=1/%h/%h",
                 edges, OUT_VALID, OUT_DATA, OUT_BYTE_EN,
                 prev_data, prev_be);
      end
    end
    if (OUT_VALID === 1'b1) begin
      valid_cycles++;
      if (!prev_valid) rise_edge = edges;
    end
    if (hs === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_word got=%h/%h want=none",
                 OUT_DATA, OUT_BYTE_EN);
      end else begin
        w = exp_q.pop_front();
        if (OUT_DATA !== w.data || OUT_BYTE_EN !== w.be) begin
          failures++;
          $display("FAIL word got=%h/%h want=%h/%h",
                   OUT_DATA, OUT_BYTE_EN, w.data, w.be);
        end
      end
    end
    prev_valid = (OUT_VALID === 1'b1) && (hs !== 1'b1) && !RST;
    prev_data  = OUT_DATA;
    prev_be    = OUT_BYTE_EN;
    @(posedge CLK);
    edges++;
    if (pop_now === 1'b1 && fq.size() != 0) begin
      void'(fq.pop_front());
      pop_edge = edges;
    end
    @(negedge CLK);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || fq.size() != 0) begin
      failures++;
      $display("FAIL drain_%s got exp=%0d fifo=%0d want 0/0",
               name, exp_q.size(), fq.size());
    end
  endtask

  task automatic pop_all(input int budget);
    int n = 0;
    while (fq.size() != 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    OUT_READY = 1'b1;
    push_word(8'h01, 8'h02, 8'h03, 8'h04);
    repeat (3) step();
    checks++;
    if (fq.size() != 4) begin
      failures++;
      $display("FAIL reset_nopop got=%0d want=4", fq.size());
    end
    RST    = 1'b0;
    EMPTY  = 1'b0;
    R_DATA = fq[0];
    #1;
    checks++;
    if (OUT_DATA !== '0 || OUT_BYTE_EN !== '0 ||
        OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got=%h/%h/%b want=0/0/0",
               OUT_DATA, OUT_BYTE_EN, OUT_VALID);
    end
    checks++;
    if (R_INC !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_pop got=%b want=1", R_INC);
    end
    step();
    checks++;
    if (fq.size() != 3) begin
      failures++;
      $display("FAIL reset_pop_edge got=%0d want=3", fq.size());
    end
    drain(20, "reset");
  endtask

  task automatic test_full_word();
    OUT_READY    = 1'b1;
    valid_cycles = 0;
    push_word(8'haa, 8'hbb, 8'hcc, 8'hdd);
    drain(20, "full");
    repeat (2) step();
    checks++;
    if (valid_cycles != 1) begin
      failures++;
      $display("FAIL full_valid_len got=%0d want=1", valid_cycles);
    end
  endtask

  task automatic test_backpressure();
    OUT_READY = 1'b0;
    push_word(8'haa, 8'hbb, 8'hcc, 8'hdd);
    push_word(8'hee, 8'hff, 8'ha1, 8'ha2);
    repeat (14) step();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'hddccbbaa) begin
      failures++;
      $display("FAIL bp_stall got=%b/%h want=1/ddccbbaa",
               OUT_VALID, OUT_DATA);
    end
    checks++;
    if (fq.size() != 4) begin
      failures++;
      $display("FAIL bp_nopop got=%0d want=4", fq.size());
    end
    OUT_READY = 1'b1;
    drain(30, "bp");
  endtask

  task automatic test_timeout();
    int last;
    OUT_READY = 1'b1;
    fq.push_back(8'hb1);
    fq.push_back(8'hb2);
`ifdef PACKER_TIMEOUT_EN
    push_exp(32'h0000b2b1, 4'h3);
    pop_all(10);
    last = pop_edge;
    drain(40, "timeout");
    checks++;
    if (rise_edge - last != TO) begin
      failures++;
      $display("FAIL timeout_lat got=%0d want=%0d",
               rise_edge - last, TO);
    end
`else
    valid_cycles = 0;
    pop_all(10);
    last = pop_edge;
    repeat (40) step();
    checks++;
    if (valid_cycles != 0 || edges - last < 40) begin
      failures++;
      $display("FAIL no_flush got=%0d want=0", valid_cycles);
    end
    fq.push_back(8'hb3);
    repeat (5) step();
    fq.push_back(8'hb4);
    push_exp(32'hb4b3b2b1, 4'hF);
    drain(20, "noflush");
`endif
  endtask

  task automatic test_timeout_race();
    int last;
    int n = 0;
    OUT_READY = 1'b1;
    fq.push_back(8'hc1);
    pop_all(10);
    last = pop_edge;
    while ((edges - last) < TO - 1 && n < 40) begin
      step();
      n++;
    end
    fq.push_back(8'hc2);
    fq.push_back(8'hc3);
    fq.push_back(8'hc4);
    push_exp(32'hc4c3c2c1, 4'hF);
    drain(20, "race");
  endtask

  task automatic test_reset_mid();
    OUT_READY = 1'b1;
    fq.push_back(8'he1);
    fq.push_back(8'he2);
    pop_all(10);
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if (OUT_DATA !== '0 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b want=0/0",
               OUT_DATA, OUT_VALID);
    end
    push_word(8'ha5, 8'ha6, 8'ha7, 8'ha8);
    drain(20, "mid");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      push_word(8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom));
    end
    while ((exp_q.size() != 0 || fq.size() != 0) && n < 300) begin
      gate_empty = ($urandom_range(0, 3) == 0);
      OUT_READY  = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    gate_empty = 1'b0;
    OUT_READY  = 1'b1;
    drain(20, "b2b");
  endtask

  initial begin
    RST       = 1'b1;
    EMPTY     = 1'b1;
    R_DATA    = '0;
    OUT_READY = 1'b0;
    @(negedge CLK);
    test_reset();
    test_full_word();
    test_backpressure();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_back_to_back();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
